pb_conditioner: RTL and testbench

//  Upstream stage of the scoreboard core. Conditions the raw active-low pushbuttons:
//   - 2-FF synchroniser
//   - per-button debounce FSM
//   - press-capture flag, held until the core's 1 Hz enable tick consumes it

---
 rtl/pb_conditioner.sv | 142 ++++++++++++++
 tb/tb_pb_conditioner.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pb_conditioner.sv
// -----------------------------------------------------------------------------
// pb_conditioner
// Conditions raw active-low pushbuttons for the scoreboard core: a two-FF
// synchroniser, a per-button debounce FSM, and a press-capture flag. The flag
// is held until the core's 1 Hz TICK consumes it, so each physical press
// counts exactly once however long it is held or however it bounces.
//
// Ports
//   CLK    in   1  system clock, all logic on posedge
//   RST    in   1  synchronous active-high reset
//   PB_N   in   N  raw pushbuttons, active-low, asynchronous to CLK
//   TICK   in   1  one-cycle consume strobe (same signal as the core's EN)
//   PB_Q   out  N  conditioned press flags, active-low (0 = press pending)
//   LEVEL  out  N  debounced button level, active-high (1 = held)
// -----------------------------------------------------------------------------
module pb_conditioner #(
    parameter int unsigned N         = 4,
    parameter int unsigned DB_CYCLES = 1_000_000,
    parameter int unsigned CW        = 20
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [N-1:0] PB_N,
    input  logic         TICK,
    output logic [N-1:0] PB_Q,
    output logic [N-1:0] LEVEL
);

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        PRESS_CHK   = 2'd1,
        PRESSED     = 2'd2,
        RELEASE_CHK = 2'd3
    } db_state_t;

    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    logic [N-1:0]  sync1;
    logic [N-1:0]  sync2;
    db_state_t     state     [N];
    db_state_t     state_nxt [N];
    logic [CW-1:0] cnt       [N];
    logic [CW-1:0] cnt_nxt   [N];
    logic [N-1:0]  accept;
    logic [N-1:0]  pending;
    logic [N-1:0]  pending_nxt;
    logic [N-1:0]  level_nxt;

    // PB_Q is the storage for the pending flag itself (active-low).
    assign pending = ~PB_Q;

    // Two-FF synchroniser; the only logic that touches raw PB_N.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= PB_N;
            sync2 <= sync1;
        end
    end

    // State, counter, level and pending-flag registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < int'(N); i++) begin
                state[i] <= RELEASED;
                cnt[i]   <= CNT_ZERO;
            end
            LEVEL <= '0;
            PB_Q  <= '1;
        end else begin
            for (int i = 0; i < int'(N); i++) begin
                state[i] <= state_nxt[i];
                cnt[i]   <= cnt_nxt[i];
            end
            LEVEL <= level_nxt;
            PB_Q  <= ~pending_nxt;
        end
    end

    // Per-button debounce next-state; a level change needs DB_CYCLES
    // consecutive agreeing synced samples.
    always_comb begin
        accept      = '0;
        level_nxt   = '0;
        pending_nxt = '0;
        for (int i = 0; i < int'(N); i++) begin
            state_nxt[i] = state[i];
            cnt_nxt[i]   = cnt[i];
            case (state[i])
                RELEASED: begin
                    if (!sync2[i]) begin
                        state_nxt[i] = PRESS_CHK;
                        cnt_nxt[i]   = CNT_ONE;
                    end else begin
                        cnt_nxt[i]   = CNT_ZERO;
                    end
                end
                PRESS_CHK: begin
                    if (sync2[i]) begin
                        state_nxt[i] = RELEASED;
                        cnt_nxt[i]   = CNT_ZERO;
                    end else if (cnt[i] == CNT_LAST) begin
                        state_nxt[i] = PRESSED;
                        cnt_nxt[i]   = CNT_ZERO;
                        accept[i]    = 1'b1;
                    end else begin
                        cnt_nxt[i]   = cnt[i] + CNT_ONE;
                    end
                end
                PRESSED: begin
                    if (sync2[i]) begin
                        state_nxt[i] = RELEASE_CHK;
                        cnt_nxt[i]   = CNT_ONE;
                    end
                end
                RELEASE_CHK: begin
                    if (!sync2[i]) begin
                        state_nxt[i] = PRESSED;
                        cnt_nxt[i]   = CNT_ZERO;
                    end else if (cnt[i] == CNT_LAST) begin
                        state_nxt[i] = RELEASED;
                        cnt_nxt[i]   = CNT_ZERO;
                    end else begin
                        cnt_nxt[i]   = cnt[i] + CNT_ONE;
                    end
                end
                default: begin
                    state_nxt[i] = RELEASED;
                    cnt_nxt[i]   = CNT_ZERO;
                end
            endcase
            level_nxt[i]   = (state_nxt[i] == PRESSED) || (state_nxt[i] == RELEASE_CHK);
            // A new press wins over a coincident TICK so it is not lost.
            pending_nxt[i] = accept[i] | (pending[i] & ~TICK);
        end
    end

endmodule

// File: tb/tb_pb_conditioner.sv
module tb_pb_conditioner;

    localparam int unsigned N  = 4;
    localparam int unsigned DB = 4;
    localparam int unsigned CW = 3;

    logic         CLK = 1'b0;
    logic         RST;
    logic         TICK;
    logic [N-1:0] PB_N;
    logic [N-1:0] PB_Q;
    logic [N-1:0] LEVEL;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [N-1:0] pb_q;
        logic [N-1:0] level;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: level flips after DB consecutive synced samples that
    // disagree with it; pending is set on a rising level, cleared by TICK.
    logic [N-1:0] m_s1, m_s2, m_level, m_pend;
    int           m_run [N];

    pb_conditioner #(.N(N), .DB_CYCLES(DB), .CW(CW)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .PB_N  (PB_N),
        .TICK  (TICK),
        .PB_Q  (PB_Q),
        .LEVEL (LEVEL)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic model_edge(input logic [N-1:0] pb, input logic t, input logic r);
        if (r) begin
            m_s1    = '1;
            m_s2    = '1;
            m_level = '0;
            m_pend  = '0;
            for (int i = 0; i < int'(N); i++) m_run[i] = 0;
        end else begin
            for (int i = 0; i < int'(N); i++) begin
                logic pressed;
                logic rose;
                pressed = ~m_s2[i];
                rose    = 1'b0;
                if (pressed != m_level[i]) begin
                    m_run[i]++;
                    if (m_run[i] == int'(DB)) begin
                        m_level[i] = pressed;
                        m_run[i]   = 0;
                        rose       = pressed;
                    end
                end else begin
                    m_run[i] = 0;
                end
                if (rose)   m_pend[i] = 1'b1;
                else if (t) m_pend[i] = 1'b0;
            end
            m_s2 = m_s1;
            m_s1 = pb;
        end
    endtask

    // One clock: drive on negedge, model the posedge, queue the expectation.
    task automatic cycle(input logic [N-1:0] pb, input logic t, input logic r);
        @(negedge CLK);
        PB_N = pb;
        TICK = t;
        RST  = r;
        @(posedge CLK);
        model_edge(pb, t, r);
        exp_q.push_back({~m_pend, m_level});
        #1;
    endtask

    task automatic run(input int n, input logic [N-1:0] pb, input logic t);
        for (int k = 0; k < n; k++) cycle(pb, t, 1'b0);
    endtask

    // Monitor: every registered output sample is compared to the scoreboard.
    initial begin
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_pb_q",  32'(PB_Q),  32'(e.pb_q));
                check("sb_level", 32'(LEVEL), 32'(e.level));
            end
        end
    end

    initial begin
        int   falls;
        logic prev;
        logic [N-1:0] pb;
        PB_N = '1;
        TICK = 1'b0;
        RST  = 1'b1;

        // Reset
        cycle('1, 1'b0, 1'b1);
        cycle('1, 1'b1, 1'b1);
        check("reset_pb_q",  32'(PB_Q),  32'hF);
        check("reset_level", 32'(LEVEL), 32'h0);
        run(2, '1, 1'b0);

        // 1: clean press on button 0, rise at edge 5
        for (int i = 0; i < 12; i++) begin
            cycle(4'b1110, 1'b0, 1'b0);
            check("t1_level0", 32'(LEVEL[0]), 32'(i >= 5));
            check("t1_pbq0",   32'(PB_Q[0]),  32'(!(i >= 5)));
        end
        check("t1_other_level", 32'(LEVEL[3:1]), 32'h0);
        check("t1_other_pbq",   32'(PB_Q[3:1]),  32'h7);
        run(8, '1, 1'b0);
        check("t1_release_level", 32'(LEVEL[0]), 32'h0);
        check("t1_release_pend",  32'(PB_Q[0]),  32'h0);
        cycle('1, 1'b1, 1'b0);
        check("t1_consumed", 32'(PB_Q), 32'hF);

        // 2: bounce on button 0, settles low at edge 12
        falls = 0;
        for (int i = 0; i < 22; i++) begin
            prev = PB_Q[0];
            pb   = '1;
            if (i >= 12 || ((i / 2) % 2) == 0) pb[0] = 1'b0;
            cycle(pb, 1'b0, 1'b0);
            if (prev && !PB_Q[0]) falls++;
            if (i < 17) check("t2_level_low", 32'(LEVEL[0]), 32'h0);
            if (i == 17) check("t2_level_rise", 32'(LEVEL[0]), 32'h1);
        end
        check("t2_one_press", 32'(falls), 32'd1);
        run(8, '1, 1'b0);
        cycle('1, 1'b1, 1'b0);

        // 3: consume on button 2, held button does not re-arm
        for (int i = 0; i < 6; i++) cycle(4'b1011, 1'b0, 1'b0);
        check("t3_pending", 32'(PB_Q[2]), 32'h0);
        cycle(4'b1011, 1'b1, 1'b0);
        check("t3_consumed", 32'(PB_Q[2]), 32'h1);
        for (int i = 0; i < 8; i++) begin
            cycle(4'b1011, 1'b0, 1'b0);
            check("t3_no_rearm", 32'(PB_Q[2]), 32'h1);
        end
        check("t3_held", 32'(LEVEL[2]), 32'h1);
        run(8, '1, 1'b0);

        // 4: second press on button 1 accepted on the TICK edge
        run(6, 4'b1101, 1'b0);
        check("t4_first", 32'(PB_Q[1]), 32'h0);
        run(6, '1, 1'b0);
        check("t4_released", 32'(LEVEL[1]), 32'h0);
        run(5, 4'b1101, 1'b0);
        cycle(4'b1101, 1'b1, 1'b0);
        check("t4_relevel",     32'(LEVEL[1]), 32'h1);
        check("t4_coincident",  32'(PB_Q[1]),  32'h0);
        cycle(4'b1101, 1'b1, 1'b0);
        check("t4_lone_tick",   32'(PB_Q[1]),  32'h1);
        run(8, '1, 1'b0);

        // 5: reset mid-debounce of button 3, button 0 pending beforehand
        run(6, 4'b1110, 1'b0);
        check("t5_pre_pend", 32'(PB_Q[0]), 32'h0);
        run(4, 4'b0110, 1'b0);
        cycle(4'b0110, 1'b1, 1'b1);
        check("t5_rst_pb_q",  32'(PB_Q),  32'hF);
        check("t5_rst_level", 32'(LEVEL), 32'h0);
        for (int i = 0; i < 8; i++) begin
            cycle(4'b0110, 1'b0, 1'b0);
            check("t5_level3", 32'(LEVEL[3]), 32'(i >= 5));
            check("t5_pbq3",   32'(PB_Q[3]),  32'(!(i >= 5)));
        end
        run(8, '1, 1'b0);
        cycle('1, 1'b1, 1'b0);
        check("t5_cleared", 32'(PB_Q), 32'hF);

        // 6: buttons 0 and 3 overlapping with random ticks
        for (int i = 0; i < 60; i++) begin
            pb = '1;
            if ((i >= 3 && i < 25) || (i >= 35 && i < 50)) pb[0] = 1'b0;
            if (i >= 10 && i < 40 && i != 12) pb[3] = 1'b0;
            cycle(pb, ($urandom_range(0, 5) == 0), 1'b0);
        end
        run(10, '1, 1'b0);
        check("t6_mid_quiet", 32'(LEVEL[2:1]), 32'h0);

        @(negedge CLK);
        @(negedge CLK);
        #1;
        check("sb_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
